// File: rtl/button_step_counter.sv
// Loadable up/down step counter driven by an active-low push button, with
// input synchronisers, falling-edge step detection and wrap/saturate/one-shot/hold modes.
module button_step_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX         = (2**WIDTH)-1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] din,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             done,
  output logic             at_zero,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_Q  = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ {1'b0, b[WIDTH-1:1]};
  endfunction

  logic [SYNC_STAGES-1:0] step_sync_r;
  logic [SYNC_STAGES-1:0] load_sync_r;
  logic                   step_prev_r;
  logic [WIDTH-1:0]       q_r;
  logic [WIDTH-1:0]       gray_r;
  logic                   tc_r;
  logic                   done_r;

  logic                   step_s;
  logic                   load_s;
  logic                   term_s;
  logic [WIDTH-1:0]       step_q_s;
  logic [WIDTH-1:0]       q_nxt_s;
  logic                   tc_nxt_s;
  logic                   done_nxt_s;

  // Synchronise both buttons; idle level is 1 so reset release never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_sync_r <= {SYNC_STAGES{1'b1}};
      load_sync_r <= {SYNC_STAGES{1'b1}};
      step_prev_r <= 1'b1;
    end else begin
      step_sync_r <= {step_sync_r[SYNC_STAGES-2:0], step_n};
      load_sync_r <= {load_sync_r[SYNC_STAGES-2:0], load_n};
      step_prev_r <= step_sync_r[SYNC_STAGES-1];
    end
  end

  assign step_s   = step_prev_r & ~step_sync_r[SYNC_STAGES-1];
  assign load_s   = ~load_sync_r[SYNC_STAGES-1];
  assign term_s   = up ? (q_r >= MAX_Q) : (q_r == ZERO_Q);
  assign step_q_s = up ? (q_r + ONE_Q) : (q_r - ONE_Q);

  // Next-state decode: load beats step, step beats hold.
  always_comb begin
    q_nxt_s    = q_r;
    tc_nxt_s   = 1'b0;
    done_nxt_s = done_r;
    if (load_s) begin
      q_nxt_s    = (din > MAX_Q) ? MAX_Q : din;
      done_nxt_s = 1'b0;
    end else if (step_s) begin
      case (mode)
        MODE_WRAP: begin
          if (term_s) begin
            q_nxt_s  = up ? ZERO_Q : MAX_Q;
            tc_nxt_s = 1'b1;
          end else begin
            q_nxt_s = step_q_s;
          end
        end
        MODE_SAT: begin
          if (term_s) begin
            tc_nxt_s = 1'b1;
          end else begin
            q_nxt_s = step_q_s;
          end
        end
        MODE_ONESHOT: begin
          // Once fired, the counter is frozen until the next load.
          if (done_r) begin
            q_nxt_s = q_r;
          end else if (term_s) begin
            tc_nxt_s   = 1'b1;
            done_nxt_s = 1'b1;
          end else begin
            q_nxt_s = step_q_s;
          end
        end
        MODE_HOLD: begin
          q_nxt_s = q_r;
        end
        default: begin
          q_nxt_s = q_r;
        end
      endcase
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Count, Gray mirror and status registers; gray is built from next-q so it never lags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= ZERO_Q;
      gray_r <= ZERO_Q;
      tc_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      gray_r <= to_gray(q_nxt_s);
      tc_r   <= tc_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign q       = q_r;
  assign gray    = gray_r;
  assign tc      = tc_r;
  assign done    = done_r;
  assign at_zero = (q_r == ZERO_Q);
  assign at_max  = (q_r == MAX_Q);

endmodule

// File: doc/button_step_counter.md
# button_step_counter

Parametrised, loadable up/down step counter driven directly by an active-low push button. It is the successor to the fixed 4-bit JK load/count block: the width and terminal value are generic, and it adds an on-chip synchroniser and falling-edge detector so the counter runs on the system clock rather than on the button. It also adds wrap, saturate, one-shot and hold modes, a terminal-count pulse and a Gray-coded mirror of the count. It sits between the KEY inputs and the binary-to-BCD/7-segment display path.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- MAX, 2**WIDTH-1, terminal count value, 1 ≤ MAX ≤ 2**WIDTH-1
- SYNC_STAGES, 2, synchroniser depth for step_n and load_n (≥2)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- step_n  in  1  asynchronous active-low step button; each falling edge is one step
- load_n  in  1  asynchronous active-low load button (level)
- din  in  WIDTH  load value
- up  in  1  1 = count up, 0 = count down
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 hold
- q  out  WIDTH  current count
- gray  out  WIDTH  registered Gray code of q (q ^ (q>>1))
- tc  out  1  one-cycle terminal-count pulse
- done  out  1  one-shot completion flag
- at_zero  out  1  combinational, q == 0
- at_max  out  1  combinational, q == MAX

## Operation
- Reset values: q=0, gray=0, tc=0, done=0. All synchroniser and edge-history flops reset to 1 (button idle), so releasing reset never creates a step or load.
- step_n and load_n each pass through a SYNC_STAGES flop chain. step = previous synchronised step_n & ~current synchronised step_n, giving a single cycle per falling edge.
- Priority each cycle: load > step > hold.
- Load (synchronised load_n low, level):
  - q ← min(din, MAX) and done ← 0.
  - Steps arriving while load is active are discarded.
- Step with the terminal condition false (up and q<MAX, or down and q>0), modes 00/01/10: q ← q±1.
- Step with the terminal condition true (up and q==MAX, or down and q==0):
  - 00 wrap: q ← 0 when counting up, MAX when counting down; tc ← 1.
  - 01 saturate: q unchanged; tc ← 1.
  - 10 one-shot: q unchanged; tc ← 1 and done ← 1. While done=1, all further steps are ignored (no tc) until a load.
- Mode 11: every step is ignored and tc stays 0.
- up and mode are sampled on the cycle the step is acted on. Changing them between steps is legal and takes effect at the next step.
- q is always ≤ MAX, except that a reset value of 0 is always legal.
- gray is updated on the same edge as q from next-q, so gray always equals the Gray code of q.
- at_zero and at_max are decoded from q with no extra latency.

## Timing
- Step latency: with step_n first sampled low at rising edge k, q/gray/tc update at edge k+SYNC_STAGES. For SYNC_STAGES=2, the change lands on the third rising edge counting edge k.
- Load latency: load_n sampled low at edge k → q=min(din,MAX) after edge k+SYNC_STAGES-1+1 = k+SYNC_STAGES. q keeps following din every cycle while load stays low.
- tc is high for exactly one clk cycle per qualifying step and is 0 in every other cycle.
- done rises on the same edge as its tc pulse and is held until the load edge.
- One step per falling edge. The minimum step_n low and high times are SYNC_STAGES+1 clk cycles each; shorter pulses may be missed but must never double-count.
- Bounce is not filtered: each clean falling edge that meets the minimum width counts.
- Reset asserted mid-operation clears all state immediately, without waiting for clk. A step edge in flight is lost.
- Simultaneous load falling edge and step falling edge: load wins and the step is discarded.

## Test plan
- Reset, then WIDTH=4, MAX=9, mode=00, up=1, 10 steps: q runs 1..9 then 0; tc pulses once, on the 9→0 step; gray=0 after the wrap.
- Mode=00, up=0, starting at q=0, one step: q=9 and tc pulses. A second step gives q=8 with no tc.
- Mode=01, up=1: load din=9, then 3 steps → q stays 9, tc pulses 3 times, and at_max=1 throughout.
- Mode=10, up=1: load din=8, then 3 steps → q=9 after step 1; tc and done rise on step 2; step 3 produces no tc. A load with din=12 then gives q=9 (clamped) and done=0.
- Hold step_n low for 1 cycle only, then for 5 cycles with SYNC_STAGES=2: the 5-cycle pulse counts exactly once and the edge latency is 2 edges after first sampling. Assert reset mid-count at q=5: q=0 immediately, with no spurious step after release.
- Mode=11, 4 steps: q unchanged and tc=0. Drive load_n and step_n low in the same cycle: q=din, with no increment.
